// File: rtl/round_pkg.sv
// Shared rounding helpers for the narrowing blocks (round_trim_right and friends).
// Round modes, clamped width difference and the nearest-even increment decision.
package round_pkg;

    typedef enum logic {
        RM_RNE   = 1'b0,
        RM_TRUNC = 1'b1
    } round_mode_e;

    // Number of discarded low bits; never negative even for a bad parameter pair.
    function automatic int diff_clamp(input int in_w, input int out_w);
        return (in_w > out_w) ? (in_w - out_w) : 0;
    endfunction

    function automatic logic round_inc(input logic lsb, input logic guard,
                                       input logic sticky, input round_mode_e mode);
        return (mode == RM_RNE) & guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/round_trim_right_if.sv
// Valid/ready bus of round_trim_right: input beat side plus output beat side.
// The block itself connects through the slave modport; the environment uses master.
interface round_trim_right_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_trunc;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_inexact;
    logic                 out_carry;

    modport slave (
        input  in_valid, in_data, in_trunc, out_ready,
        output in_ready, out_valid, out_data, out_inexact, out_carry
    );

    modport master (
        output in_valid, in_data, in_trunc, out_ready,
        input  in_ready, out_valid, out_data, out_inexact, out_carry
    );
endinterface

// File: rtl/round_trim_guard.sv
// Splits an MSB-aligned significand into kept bits, guard bit and sticky OR.
// Generate branches keep the DIFF==0 and DIFF==1 cases free of zero-width selects.
module round_trim_guard
    import round_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic [IN_WIDTH-1:0]  data_i,
    output logic [OUT_WIDTH-1:0] kept_o,
    output logic                 guard_o,
    output logic                 sticky_o
);
    localparam int DIFF = diff_clamp(IN_WIDTH, OUT_WIDTH);

    assign kept_o = data_i[IN_WIDTH-1 -: OUT_WIDTH];

    generate
        if (DIFF == 0) begin : g_pass
            assign guard_o  = 1'b0;
            assign sticky_o = 1'b0;
        end else if (DIFF == 1) begin : g_guard_only
            assign guard_o  = data_i[0];
            assign sticky_o = 1'b0;
        end else begin : g_guard_sticky
            assign guard_o  = data_i[DIFF-1];
            assign sticky_o = |data_i[DIFF-2:0];
        end
    endgenerate
endmodule

// File: rtl/round_trim_right.sv
// Two-stage narrowing rounder: RNE or truncate, with inexact and carry-out flags.
// Build option ROUND_TRIM_SATURATE_EN: clamp an overflowing result to all-ones instead of wrapping.
module round_trim_right
    import round_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    round_trim_right_if.slave bus
);
    generate
        if (IN_WIDTH < OUT_WIDTH || OUT_WIDTH < 1) begin : g_bad_width
            $error("round_trim_right: need IN_WIDTH >= OUT_WIDTH >= 1");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] ext_kept;
    logic                 ext_guard;
    logic                 ext_sticky;

    round_trim_guard #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_guard (
        .data_i   (bus.in_data),
        .kept_o   (ext_kept),
        .guard_o  (ext_guard),
        .sticky_o (ext_sticky)
    );

    // S1 holds the extracted fields, S2 the finished result driving the bus.
    logic                 s1_valid_q,  s1_valid_d;
    logic [OUT_WIDTH-1:0] s1_kept_q,   s1_kept_d;
    logic                 s1_guard_q,  s1_guard_d;
    logic                 s1_sticky_q, s1_sticky_d;
    round_mode_e          s1_mode_q,   s1_mode_d;

    logic                 out_valid_q,   out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q,    out_data_d;
    logic                 out_inexact_q, out_inexact_d;
    logic                 out_carry_q,   out_carry_d;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv = ~out_valid_q | bus.out_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;
    assign accept = bus.in_valid & s1_adv & ~reset;

    assign bus.in_ready    = s1_adv & ~reset;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_inexact = out_inexact_q;
    assign bus.out_carry   = out_carry_q;

    logic                 res_inc;
    logic [OUT_WIDTH:0]   res_sum;
    logic [OUT_WIDTH-1:0] res_data;
    logic                 res_inexact;
    logic                 res_carry;

    always_comb begin
        res_inc   = round_inc(s1_kept_q[0], s1_guard_q, s1_sticky_q, s1_mode_q);
        res_sum   = {1'b0, s1_kept_q} + {{OUT_WIDTH{1'b0}}, res_inc};
        res_carry = res_sum[OUT_WIDTH];
`ifdef ROUND_TRIM_SATURATE_EN
        res_data    = res_carry ? {OUT_WIDTH{1'b1}} : res_sum[OUT_WIDTH-1:0];
        res_inexact = s1_guard_q | s1_sticky_q | res_carry;
`else
        // Wrapped value is 0 on overflow; the encoder consumes out_carry.
        res_data    = res_sum[OUT_WIDTH-1:0];
        res_inexact = s1_guard_q | s1_sticky_q;
`endif
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_kept_d   = s1_kept_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_mode_d   = s1_mode_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_kept_d   = ext_kept;
                s1_guard_d  = ext_guard;
                s1_sticky_d = ext_sticky;
                s1_mode_d   = bus.in_trunc ? RM_TRUNC : RM_RNE;
            end
        end
    end

    // Result registers only load when S1 hands over a beat, so a stalled output stays put.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_inexact_d = out_inexact_q;
        out_carry_d   = out_carry_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d    = res_data;
                out_inexact_d = res_inexact;
                out_carry_d   = res_carry;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_kept_q     <= '0;
            s1_guard_q    <= 1'b0;
            s1_sticky_q   <= 1'b0;
            s1_mode_q     <= RM_RNE;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
            out_carry_q   <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_kept_q     <= s1_kept_d;
            s1_guard_q    <= s1_guard_d;
            s1_sticky_q   <= s1_sticky_d;
            s1_mode_q     <= s1_mode_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
            out_carry_q   <= out_carry_d;
        end
    end
endmodule

// File: tb/tb_round_trim_right.sv
// Bench for round_trim_right: directed vectors, backpressure, mid-flight reset,
// parameter corners (8/8 and 9/8) and a randomized run against an arithmetic model.
module tb_round_trim_right;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    round_trim_right_if #(.IN_WIDTH(16), .OUT_WIDTH(8)) b16 ();
    round_trim_right_if #(.IN_WIDTH(8),  .OUT_WIDTH(8)) b8 ();
    round_trim_right_if #(.IN_WIDTH(9),  .OUT_WIDTH(8)) b9 ();

    round_trim_right #(.IN_WIDTH(16), .OUT_WIDTH(8)) u16 (.clock(clock), .reset(reset), .bus(b16));
    round_trim_right #(.IN_WIDTH(8),  .OUT_WIDTH(8)) u8  (.clock(clock), .reset(reset), .bus(b8));
    round_trim_right #(.IN_WIDTH(9),  .OUT_WIDTH(8)) u9  (.clock(clock), .reset(reset), .bus(b9));

`ifdef ROUND_TRIM_SATURATE_EN
    localparam logic [7:0] OVF = 8'hFF;
`else
    localparam logic [7:0] OVF = 8'h00;
`endif

    typedef struct {
        logic [7:0] data;
        bit         inex;
        bit         carry;
    } res_t;

    typedef struct {
        logic [15:0] din;
        bit          trunc;
        logic [7:0]  data;
        bit          inex;
        bit          carry;
        int          acc;
        int          lat;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t offer_q[$];
    beat_t sb_q[$];
    beat_t acc_e;
    beat_t mon_e;
    bit    fire   = 1'b0;
    bit    gap_en = 1'b0;
    bit    hold_v = 1'b0;
    logic [7:0] hold_d;
    logic [1:0] hold_f;

    always @(posedge clock) cyc <= cyc + 1;

    // Rounding by value: quotient, remainder against half an LSB, parity on ties.
    function automatic res_t ref_round(input int iw, input int ow, input longint unsigned din, input bit trunc);
        res_t r;
        int d = iw - ow;
        longint unsigned q    = din >> d;
        longint unsigned rem  = din - (q << d);
        longint unsigned half = (d > 0) ? (64'd1 << (d - 1)) : 64'd0;
        longint unsigned lim  = 64'd1 << ow;
        longint unsigned v    = q;
        if (!trunc && d > 0 && (rem > half || (rem == half && (q % 2) == 1))) v = q + 1;
        r.inex  = (rem != 0);
        r.carry = (v >= lim);
        if (r.carry) begin
`ifdef ROUND_TRIM_SATURATE_EN
            r.data = 8'hFF;
            r.inex = 1'b1;
`else
            r.data = 8'(v - lim);
`endif
        end else begin
            r.data = 8'(v);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push16(input logic [15:0] din, input bit trunc, input logic [7:0] data,
                          input bit inex, input bit carry, input int lat);
        beat_t b;
        b.din = din; b.trunc = trunc; b.data = data; b.inex = inex; b.carry = carry;
        b.acc = 0; b.lat = lat;
        offer_q.push_back(b);
    endtask

    task automatic push16_rand(input logic [15:0] din, input bit trunc);
        res_t r = ref_round(16, 8, 64'(din), trunc);
        push16(din, trunc, r.data, r.inex, r.carry, 0);
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n = 0;
        while ((offer_q.size() != 0 || sb_q.size() != 0) && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (offer_q.size() != 0 || sb_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=%0d pending expected=0 pending", tag, offer_q.size() + sb_q.size());
        end
    endtask

    // Input driver for the 16/8 instance; valid never looks at ready.
    always begin
        @(posedge clock);
        #1;
        if (fire) begin
            offer_q.delete(0);
            fire = 1'b0;
        end
        if (offer_q.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            b16.in_valid = 1'b1;
            b16.in_data  = offer_q[0].din;
            b16.in_trunc = offer_q[0].trunc;
        end else begin
            b16.in_valid = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (b16.in_valid && b16.in_ready) begin
            acc_e     = offer_q[0];
            acc_e.acc = cyc;
            sb_q.push_back(acc_e);
            fire = 1'b1;
        end
    end

    // Output monitor: stall stability, ordering, values and unstalled latency.
    always @(negedge clock) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(b16.out_valid), 32'd1);
                chk("hold_data", 32'(b16.out_data), 32'(hold_d));
                chk("hold_flags", 32'({b16.out_inexact, b16.out_carry}), 32'(hold_f));
            end
            hold_v = b16.out_valid && !b16.out_ready;
            hold_d = b16.out_data;
            hold_f = {b16.out_inexact, b16.out_carry};
            if (b16.out_valid && b16.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL spurious_beat observed=%0h expected=no beat", b16.out_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_data", 32'(b16.out_data), 32'(mon_e.data));
                    chk("out_inexact", 32'(b16.out_inexact), 32'(mon_e.inex));
                    chk("out_carry", 32'(b16.out_carry), 32'(mon_e.carry));
                    if (mon_e.lat != 0) chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                end
            end
        end
    end

    task automatic corner8(input logic [7:0] d, input bit tr, input res_t e);
        @(posedge clock); #1;
        b8.in_valid = 1'b1; b8.in_data = d; b8.in_trunc = tr;
        @(negedge clock);
        chk("c8_in_ready", 32'(b8.in_ready), 32'd1);
        @(posedge clock); #1;
        b8.in_valid = 1'b0;
        @(negedge clock);
        chk("c8_early_valid", 32'(b8.out_valid), 32'd0);
        @(negedge clock);
        chk("c8_valid", 32'(b8.out_valid), 32'd1);
        chk("c8_data", 32'(b8.out_data), 32'(e.data));
        chk("c8_inexact", 32'(b8.out_inexact), 32'(e.inex));
        chk("c8_carry", 32'(b8.out_carry), 32'(e.carry));
    endtask

    task automatic corner9(input logic [8:0] d, input bit tr, input res_t e);
        @(posedge clock); #1;
        b9.in_valid = 1'b1; b9.in_data = d; b9.in_trunc = tr;
        @(negedge clock);
        chk("c9_in_ready", 32'(b9.in_ready), 32'd1);
        @(posedge clock); #1;
        b9.in_valid = 1'b0;
        @(negedge clock);
        chk("c9_early_valid", 32'(b9.out_valid), 32'd0);
        @(negedge clock);
        chk("c9_valid", 32'(b9.out_valid), 32'd1);
        chk("c9_data", 32'(b9.out_data), 32'(e.data));
        chk("c9_inexact", 32'(b9.out_inexact), 32'(e.inex));
        chk("c9_carry", 32'(b9.out_carry), 32'(e.carry));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t e;
        logic [15:0] rd;
        reset = 1'b1;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_trunc = 1'b0; b16.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_trunc  = 1'b0; b8.out_ready  = 1'b1;
        b9.in_valid  = 1'b0; b9.in_data  = '0; b9.in_trunc  = 1'b0; b9.out_ready  = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(b16.out_valid), 32'd0);
        chk("rst_out_data", 32'(b16.out_data), 32'd0);
        chk("rst_out_inexact", 32'(b16.out_inexact), 32'd0);
        chk("rst_out_carry", 32'(b16.out_carry), 32'd0);
        chk("rst_in_ready", 32'(b16.in_ready), 32'd0);
        chk("rst_in_ready8", 32'(b8.in_ready), 32'd0);
        chk("rst_out_valid9", 32'(b9.out_valid), 32'd0);
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        chk("in_ready_after_rst", 32'(b16.in_ready), 32'd1);
        chk("in_ready_after_rst9", 32'(b9.in_ready), 32'd1);

        // Directed rounding vectors, back to back, each 2 cycles from accept.
        push16(16'h1280, 1'b0, 8'h12, 1'b1, 1'b0, 2);
        push16(16'h1380, 1'b0, 8'h14, 1'b1, 1'b0, 2);
        push16(16'h1281, 1'b0, 8'h13, 1'b1, 1'b0, 2);
        push16(16'h127F, 1'b0, 8'h12, 1'b1, 1'b0, 2);
        push16(16'h3400, 1'b0, 8'h34, 1'b0, 1'b0, 2);
        push16(16'h12FF, 1'b1, 8'h12, 1'b1, 1'b0, 2);
        push16(16'hFF80, 1'b0, OVF,   1'b1, 1'b1, 2);
        push16(16'hFFC0, 1'b0, OVF,   1'b1, 1'b1, 2);
        push16(16'hFFC0, 1'b1, 8'hFF, 1'b1, 1'b0, 2);
        wait_drain(100, "directed");

        // Backpressure: two beats absorbed, then a gapless drain in order.
        @(posedge clock); #2;
        b16.out_ready = 1'b0;
        push16(16'h0100, 1'b0, 8'h01, 1'b0, 1'b0, 0);
        push16(16'h0200, 1'b0, 8'h02, 1'b0, 1'b0, 0);
        push16(16'h0300, 1'b0, 8'h03, 1'b0, 1'b0, 0);
        push16(16'h0400, 1'b0, 8'h04, 1'b0, 1'b0, 0);
        repeat (6) @(negedge clock);
        chk("bp_accepted", 32'(sb_q.size()), 32'd2);
        chk("bp_in_ready", 32'(b16.in_ready), 32'd0);
        chk("bp_out_valid", 32'(b16.out_valid), 32'd1);
        chk("bp_stall_data", 32'(b16.out_data), 32'h01);
        @(negedge clock);
        chk("bp_stall_data2", 32'(b16.out_data), 32'h01);
        @(posedge clock); #2;
        b16.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk("bp_drain_valid", 32'(b16.out_valid), 32'd1);
            chk("bp_drain_data", 32'(b16.out_data), 32'(k));
        end
        wait_drain(50, "backpressure");

        // Reset with two beats in flight: nothing stale may come out.
        @(posedge clock); #2;
        b16.out_ready = 1'b0;
        push16(16'h0A00, 1'b0, 8'h0A, 1'b0, 1'b0, 0);
        push16(16'h0B00, 1'b0, 8'h0B, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20 && sb_q.size() < 2; i++) @(negedge clock);
        chk("mid_accepted", 32'(sb_q.size()), 32'd2);
        @(posedge clock); #2;
        reset = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        b16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_valid", 32'(b16.out_valid), 32'd0);
            chk("post_rst_data", 32'(b16.out_data), 32'd0);
        end
        push16(16'h0580, 1'b0, 8'h06, 1'b1, 1'b0, 2);
        wait_drain(50, "post_reset");

        // Parameter corners.
        e.data = 8'hA5; e.inex = 1'b0; e.carry = 1'b0;
        corner8(8'hA5, 1'b0, e);
        e.data = OVF; e.inex = 1'b1; e.carry = 1'b1;
        corner9(9'h1FF, 1'b0, e);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d8;
            logic [8:0] d9;
            bit t;
            d8 = 8'($urandom);
            d9 = 9'($urandom);
            t  = 1'($urandom);
            corner8(d8, t, ref_round(8, 8, 64'(d8), t));
            corner9(d9, t, ref_round(9, 8, 64'(d9), t));
        end

        // Randomized traffic with input gaps and random output stalls.
        gap_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rd[7:0] = 8'h80;
            if ($urandom_range(0, 7) == 0) rd[15:8] = 8'hFF;
            push16_rand(rd, ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 5000 && (offer_q.size() != 0 || sb_q.size() != 0); i++) begin
            @(posedge clock); #2;
            b16.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock); #2;
        b16.out_ready = 1'b1;
        wait_drain(100, "random");
        gap_en = 1'b0;

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
